multi_mode_timing: RTL and testbench
====================================

MULTI_MODE_TIMING -- requirements
Module: multi_mode_timing

Interface
REQ-001 The block SHALL have parameter CW, default 12, giving the counter and coordinate width.
REQ-002 The block SHALL have parameters H_ACTn/H_FPn/H_SYNCn/H_BPn, for n=0,1, with defaults 640/16/96/48 (mode 0) and 320/8/48/24 (mode 1), giving horizontal active pixels, front porch, sync and back porch.
REQ-003 The block SHALL have parameters V_ACTn/V_FPn/V_SYNCn/V_BPn, with defaults 480/10/2/33 (mode 0) and 240/3/3/16 (mode 1), giving the vertical equivalents in lines.
REQ-004 The block SHALL have parameters HS_POLn and VS_POLn, default 0, giving the sync active level per mode.
REQ-005 The block SHALL have parameters SHIFTn, defaults 1 (mode 0) and 0 (mode 1), giving the coordinate downscale shift (0..2).
REQ-006 clk  in  1  pixel-domain clock.
REQ-007 nreset  in  1  asynchronous, active-low reset.
REQ-008 clkEn  in  1  pixel strobe; the state advances only on edges where clkEn=1.
REQ-009 modeSel  in  1  requested timing mode.
REQ-010 modeActive  out  1  mode currently in effect.
REQ-011 h_count, v_count  out  CW  raw position including blanking.
REQ-012 hsync, vsync, csync  out  1  sync outputs at the active-mode polarity; csync is always active-low.
REQ-013 blank  out  1  high outside the active area.
REQ-014 px_x, px_y  out  CW  scaled active coordinates.
REQ-015 lineStart, frameDrawn  out  1  single-strobe event pulses.

Function
REQ-016 For the active mode m, H_TOT=H_ACTm+H_FPm+H_SYNCm+H_BPm and V_TOT is defined likewise; the line order SHALL be active, front porch, sync, back porch.
REQ-017 On an enabled edge, h_count SHALL increment; at H_TOT-1 it SHALL wrap to 0 and v_count SHALL increment; at V_TOT-1 v_count SHALL wrap to 0.
REQ-018 With clkEn=0, all outputs SHALL hold their values, and lineStart and frameDrawn SHALL be 0.
REQ-019 All outputs SHALL be registered and computed from the next counter values, so decoded signals are cycle-aligned with the h_count/v_count presented, with zero offset.
REQ-020 blank SHALL equal (h_count>=H_ACTm) OR (v_count>=V_ACTm).
REQ-021 hsync SHALL equal HS_POLm when h_count is in [H_ACTm+H_FPm, H_ACTm+H_FPm+H_SYNCm), and ~HS_POLm otherwise.
REQ-022 vsync SHALL follow the same rule as REQ-021 on v_count with the V parameters, independent of h_count.
REQ-023 csync SHALL be 0 when exactly one of the internal hsync-active or vsync-active flags is true (XOR), and 1 otherwise.
REQ-024 When blank=0, px_x SHALL equal h_count>>SHIFTm and px_y SHALL equal v_count>>SHIFTm; when blank=1, both SHALL be 0.
REQ-025 lineStart SHALL be 1 for the one enabled cycle in which h_count=0.
REQ-026 frameDrawn SHALL be 1 for the one enabled cycle in which h_count=0 and v_count=V_ACTm.
REQ-027 modeSel SHALL be sampled only on the enabled edge that wraps (H_TOT-1, V_TOT-1) to (0,0); the new mode SHALL govern that (0,0) cycle and all decoding thereafter.
REQ-028 modeSel changes at any other time SHALL be ignored until the next frame wrap; multiple toggles within a frame SHALL resolve to the last value present at the wrap.
REQ-029 Counters SHALL never exceed H_TOT-1 or V_TOT-1 of the active mode.
REQ-030 Parameter validity (all ACT/SYNC values >=1, totals < 2^CW) SHALL be checked at elaboration; violation SHALL be a fatal error.

Reset
REQ-031 While nreset=0: modeActive=0, h_count=H_TOT0-1, v_count=V_TOT0-1, blank=1, hsync=~HS_POL0, vsync=~VS_POL0, csync=1, px_x=px_y=0, lineStart=0, frameDrawn=0.
REQ-032 The first enabled edge after reset release SHALL perform the frame wrap of REQ-027, so the frame starts at (0,0) in the mode given by modeSel.
REQ-033 Reset asserted mid-frame SHALL immediately force the REQ-031 values, with no residual pulses.

Verification
REQ-034 Defaults, modeSel=0, clkEn=1: lineStart period is 800 cycles; frameDrawn period is 420000 cycles; hsync is low for h 656..751; vsync is low for v 490..491; blank=0 for 307200 cycles per frame.
REQ-035 Mode 0 at h=641, v=100 gives blank=1 and px_x=0; at h=639, v=479 it gives px_x=319, px_y=239.
REQ-036 modeSel toggled 0->1->0->1 mid-frame: modeActive changes exactly once, at the wrap, and the next line period is 400 cycles.
REQ-037 clkEn driven as 1-of-4 strobe: the same sequences as REQ-034 result, each pulse is one cycle wide, and the period is x4 in clk cycles.
REQ-038 nreset asserted at h=300, v=200: REQ-031 values hold during reset; the first enabled edge after release produces (0,0) with lineStart=1 and blank=0.
REQ-039 csync at v=490, h=700: hsync and vsync are both active, so csync=1; at v=100, h=700, csync=0.

Source files
------------

// File: rtl/multi_mode_timing.sv
// Two-mode raster timing generator: h/v counters with sync, blank and scaled pixel
// coordinates; a requested mode switch takes effect only at the frame wrap.
module multi_mode_timing #(
    parameter int CW      = 12,
    parameter int H_ACT0  = 640,
    parameter int H_FP0   = 16,
    parameter int H_SYNC0 = 96,
    parameter int H_BP0   = 48,
    parameter int H_ACT1  = 320,
    parameter int H_FP1   = 8,
    parameter int H_SYNC1 = 48,
    parameter int H_BP1   = 24,
    parameter int V_ACT0  = 480,
    parameter int V_FP0   = 10,
    parameter int V_SYNC0 = 2,
    parameter int V_BP0   = 33,
    parameter int V_ACT1  = 240,
    parameter int V_FP1   = 3,
    parameter int V_SYNC1 = 3,
    parameter int V_BP1   = 16,
    parameter bit HS_POL0 = 1'b0,
    parameter bit HS_POL1 = 1'b0,
    parameter bit VS_POL0 = 1'b0,
    parameter bit VS_POL1 = 1'b0,
    parameter int SHIFT0  = 1,
    parameter int SHIFT1  = 0
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          clkEn,
    input  logic          modeSel,
    output logic          modeActive,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          hsync,
    output logic          vsync,
    output logic          csync,
    output logic          blank,
    output logic [CW-1:0] px_x,
    output logic [CW-1:0] px_y,
    output logic          lineStart,
    output logic          frameDrawn
);

    localparam int H_TOT0 = H_ACT0 + H_FP0 + H_SYNC0 + H_BP0;
    localparam int H_TOT1 = H_ACT1 + H_FP1 + H_SYNC1 + H_BP1;
    localparam int V_TOT0 = V_ACT0 + V_FP0 + V_SYNC0 + V_BP0;
    localparam int V_TOT1 = V_ACT1 + V_FP1 + V_SYNC1 + V_BP1;

    if (H_ACT0 < 1 || H_SYNC0 < 1 || H_ACT1 < 1 || H_SYNC1 < 1 ||
        V_ACT0 < 1 || V_SYNC0 < 1 || V_ACT1 < 1 || V_SYNC1 < 1 ||
        H_FP0 < 0 || H_BP0 < 0 || H_FP1 < 0 || H_BP1 < 0 ||
        V_FP0 < 0 || V_BP0 < 0 || V_FP1 < 0 || V_BP1 < 0 ||
        H_TOT0 >= (1 << CW) || H_TOT1 >= (1 << CW) ||
        V_TOT0 >= (1 << CW) || V_TOT1 >= (1 << CW) ||
        SHIFT0 < 0 || SHIFT0 > 2 || SHIFT1 < 0 || SHIFT1 > 2) begin : g_bad_params
        $fatal(1, "multi_mode_timing: invalid timing parameters");
    end

    localparam logic [CW-1:0] H_LAST0 = CW'(H_TOT0 - 1);
    localparam logic [CW-1:0] H_LAST1 = CW'(H_TOT1 - 1);
    localparam logic [CW-1:0] V_LAST0 = CW'(V_TOT0 - 1);
    localparam logic [CW-1:0] V_LAST1 = CW'(V_TOT1 - 1);
    localparam logic [CW-1:0] H_SS0   = CW'(H_ACT0 + H_FP0);
    localparam logic [CW-1:0] H_SS1   = CW'(H_ACT1 + H_FP1);
    localparam logic [CW-1:0] H_SE0   = CW'(H_ACT0 + H_FP0 + H_SYNC0);
    localparam logic [CW-1:0] H_SE1   = CW'(H_ACT1 + H_FP1 + H_SYNC1);
    localparam logic [CW-1:0] V_SS0   = CW'(V_ACT0 + V_FP0);
    localparam logic [CW-1:0] V_SS1   = CW'(V_ACT1 + V_FP1);
    localparam logic [CW-1:0] V_SE0   = CW'(V_ACT0 + V_FP0 + V_SYNC0);
    localparam logic [CW-1:0] V_SE1   = CW'(V_ACT1 + V_FP1 + V_SYNC1);

    logic          mode_n;
    logic [CW-1:0] h_n, v_n;
    logic [CW-1:0] h_last_c, v_last_c;
    logic [CW-1:0] h_act_n, h_ss_n, h_se_n, v_act_n, v_ss_n, v_se_n;
    logic          hs_pol_n, vs_pol_n;
    logic [1:0]    shift_n;
    logic          hs_act, vs_act, blank_n;

    // Wrap limits come from the mode in effect; >= keeps counters bounded even from a corrupt state.
    always_comb begin
        h_last_c = modeActive ? H_LAST1 : H_LAST0;
        v_last_c = modeActive ? V_LAST1 : V_LAST0;
        mode_n   = modeActive;
        h_n      = h_count;
        v_n      = v_count;
        if (h_count >= h_last_c) begin
            h_n = '0;
            if (v_count >= v_last_c) begin
                v_n    = '0;
                mode_n = modeSel;
            end else begin
                v_n = v_count + CW'(1);
            end
        end else begin
            h_n = h_count + CW'(1);
        end
    end

    // Decode from the next position in the next mode so registered outputs align with the counters.
    always_comb begin
        h_act_n  = mode_n ? CW'(H_ACT1) : CW'(H_ACT0);
        h_ss_n   = mode_n ? H_SS1 : H_SS0;
        h_se_n   = mode_n ? H_SE1 : H_SE0;
        v_act_n  = mode_n ? CW'(V_ACT1) : CW'(V_ACT0);
        v_ss_n   = mode_n ? V_SS1 : V_SS0;
        v_se_n   = mode_n ? V_SE1 : V_SE0;
        hs_pol_n = mode_n ? HS_POL1 : HS_POL0;
        vs_pol_n = mode_n ? VS_POL1 : VS_POL0;
        shift_n  = mode_n ? 2'(SHIFT1) : 2'(SHIFT0);
        hs_act   = (h_n >= h_ss_n) && (h_n < h_se_n);
        vs_act   = (v_n >= v_ss_n) && (v_n < v_se_n);
        blank_n  = (h_n >= h_act_n) || (v_n >= v_act_n);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            modeActive <= 1'b0;
            h_count    <= H_LAST0;
            v_count    <= V_LAST0;
            hsync      <= ~HS_POL0;
            vsync      <= ~VS_POL0;
            csync      <= 1'b1;
            blank      <= 1'b1;
            px_x       <= '0;
            px_y       <= '0;
            lineStart  <= 1'b0;
            frameDrawn <= 1'b0;
        end else begin
            lineStart  <= 1'b0;
            frameDrawn <= 1'b0;
            if (clkEn) begin
                modeActive <= mode_n;
                h_count    <= h_n;
                v_count    <= v_n;
                hsync      <= hs_act ? hs_pol_n : ~hs_pol_n;
                vsync      <= vs_act ? vs_pol_n : ~vs_pol_n;
                csync      <= ~(hs_act ^ vs_act);
                blank      <= blank_n;
                px_x       <= blank_n ? '0 : (h_n >> shift_n);
                px_y       <= blank_n ? '0 : (v_n >> shift_n);
                lineStart  <= (h_n == '0);
                frameDrawn <= (h_n == '0) && (v_n == v_act_n);
            end
        end
    end

endmodule

// File: tb/tb_multi_mode_timing.sv
// Randomized bench for multi_mode_timing: a linear frame-position model predicts
// every output each cycle under random strobes, mode requests and resets.
module tb_multi_mode_timing;

    localparam int CW = 8;
    localparam int H_ACT0 = 16, H_FP0 = 2, H_SYNC0 = 3, H_BP0 = 2;
    localparam int H_ACT1 = 8,  H_FP1 = 1, H_SYNC1 = 2, H_BP1 = 1;
    localparam int V_ACT0 = 10, V_FP0 = 2, V_SYNC0 = 2, V_BP0 = 3;
    localparam int V_ACT1 = 6,  V_FP1 = 1, V_SYNC1 = 1, V_BP1 = 2;
    localparam int SHIFT0 = 1, SHIFT1 = 2;

    localparam int HA [2] = '{H_ACT0, H_ACT1};
    localparam int HF [2] = '{H_FP0, H_FP1};
    localparam int HS [2] = '{H_SYNC0, H_SYNC1};
    localparam int HB [2] = '{H_BP0, H_BP1};
    localparam int VA [2] = '{V_ACT0, V_ACT1};
    localparam int VF [2] = '{V_FP0, V_FP1};
    localparam int VS [2] = '{V_SYNC0, V_SYNC1};
    localparam int VB [2] = '{V_BP0, V_BP1};
    localparam int HP [2] = '{0, 1};
    localparam int VP [2] = '{0, 1};
    localparam int SH [2] = '{SHIFT0, SHIFT1};

    logic          clk = 1'b0;
    logic          nreset, clkEn, modeSel;
    logic          modeActive, hsync, vsync, csync, blank, lineStart, frameDrawn;
    logic [CW-1:0] h_count, v_count, px_x, px_y;

    int n_cmp = 0;
    int n_err = 0;

    int m_pos, m_mode;
    bit m_pulse;

    multi_mode_timing #(
        .CW(CW),
        .H_ACT0(H_ACT0), .H_FP0(H_FP0), .H_SYNC0(H_SYNC0), .H_BP0(H_BP0),
        .H_ACT1(H_ACT1), .H_FP1(H_FP1), .H_SYNC1(H_SYNC1), .H_BP1(H_BP1),
        .V_ACT0(V_ACT0), .V_FP0(V_FP0), .V_SYNC0(V_SYNC0), .V_BP0(V_BP0),
        .V_ACT1(V_ACT1), .V_FP1(V_FP1), .V_SYNC1(V_SYNC1), .V_BP1(V_BP1),
        .HS_POL0(1'b0), .HS_POL1(1'b1), .VS_POL0(1'b0), .VS_POL1(1'b1),
        .SHIFT0(SHIFT0), .SHIFT1(SHIFT1)
    ) dut (
        .clk(clk), .nreset(nreset), .clkEn(clkEn), .modeSel(modeSel),
        .modeActive(modeActive), .h_count(h_count), .v_count(v_count),
        .hsync(hsync), .vsync(vsync), .csync(csync), .blank(blank),
        .px_x(px_x), .px_y(px_y), .lineStart(lineStart), .frameDrawn(frameDrawn)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ht(input int m);
        return HA[m] + HF[m] + HS[m] + HB[m];
    endfunction

    function automatic int vt(input int m);
        return VA[m] + VF[m] + VS[m] + VB[m];
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_pos   = ht(0) * vt(0) - 1;
        m_pulse = 0;
    endtask

    task automatic check_all();
        int h, v;
        bit bl, hsa, vsa;
        h   = m_pos % ht(m_mode);
        v   = m_pos / ht(m_mode);
        bl  = (h >= HA[m_mode]) || (v >= VA[m_mode]);
        hsa = (h >= HA[m_mode] + HF[m_mode]) && (h < HA[m_mode] + HF[m_mode] + HS[m_mode]);
        vsa = (v >= VA[m_mode] + VF[m_mode]) && (v < VA[m_mode] + VF[m_mode] + VS[m_mode]);
        chk_val("modeActive", 32'(modeActive), 32'(m_mode));
        chk_val("h_count", 32'(h_count), 32'(h));
        chk_val("v_count", 32'(v_count), 32'(v));
        chk_val("blank", 32'(blank), 32'(bl));
        chk_val("hsync", 32'(hsync), 32'(hsa ? HP[m_mode] : 1 - HP[m_mode]));
        chk_val("vsync", 32'(vsync), 32'(vsa ? VP[m_mode] : 1 - VP[m_mode]));
        chk_val("csync", 32'(csync), 32'(hsa == vsa));
        chk_val("px_x", 32'(px_x), 32'(bl ? 0 : h / (1 << SH[m_mode])));
        chk_val("px_y", 32'(px_y), 32'(bl ? 0 : v / (1 << SH[m_mode])));
        chk_val("lineStart", 32'(lineStart), 32'(m_pulse && h == 0));
        chk_val("frameDrawn", 32'(frameDrawn), 32'(m_pulse && h == 0 && v == VA[m_mode]));
    endtask

    task automatic check_reset_vals();
        chk_val("rst_mode", 32'(modeActive), 0);
        chk_val("rst_h", 32'(h_count), 32'(ht(0) - 1));
        chk_val("rst_v", 32'(v_count), 32'(vt(0) - 1));
        chk_val("rst_blank", 32'(blank), 1);
        chk_val("rst_hsync", 32'(hsync), 1);
        chk_val("rst_vsync", 32'(vsync), 1);
        chk_val("rst_csync", 32'(csync), 1);
        chk_val("rst_px", 32'({px_x, px_y}), 0);
        chk_val("rst_pulses", 32'({lineStart, frameDrawn}), 0);
    endtask

    task automatic step(input bit en, input bit ms);
        clkEn   = en;
        modeSel = ms;
        @(posedge clk);
        if (!nreset) begin
            model_reset();
        end else if (en) begin
            if (m_pos == ht(m_mode) * vt(m_mode) - 1) begin
                m_pos  = 0;
                m_mode = ms;
            end else begin
                m_pos++;
            end
            m_pulse = 1;
        end else begin
            m_pulse = 0;
        end
        #1;
        check_all();
    endtask

    initial begin
        int strobe;
        nreset  = 1'b1;
        clkEn   = 1'b0;
        modeSel = 1'b0;
        model_reset();
        #1 nreset = 1'b0;
        #2 check_reset_vals();
        for (int i = 0; i < 4; i++) step(1'($urandom), 1'($urandom));
        check_reset_vals();

        // First enabled edge after release wraps into (0,0) of the requested mode.
        nreset = 1'b1;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        chk_val("first_h", 32'(h_count), 0);
        chk_val("first_line", 32'(lineStart), 1);

        for (int i = 0; i < 2 * 23 * 17 + 5; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 2500; i++) step(1'b1, 1'($urandom));

        strobe = 0;
        for (int i = 0; i < 3000; i++) begin
            step(strobe == 0, 1'($urandom_range(0, 3) == 0));
            strobe = (strobe + 1) % 4;
        end

        for (int i = 0; i < 3000; i++) step($urandom_range(0, 2) != 0, 1'($urandom));

        // Asynchronous resets landing at random points mid-frame.
        for (int r = 0; r < 6; r++) begin
            int run;
            run = $urandom_range(20, 400);
            for (int i = 0; i < run; i++) step(1'($urandom), 1'($urandom));
            nreset = 1'b0;
            #2;
            model_reset();
            check_reset_vals();
            check_all();
            for (int i = 0; i < 3; i++) step(1'($urandom), 1'($urandom));
            nreset = 1'b1;
            step(1'b1, 1'b1);
            chk_val("post_rst_h", 32'(h_count), 0);
            chk_val("post_rst_v", 32'(v_count), 0);
            chk_val("post_rst_line", 32'(lineStart), 1);
            chk_val("post_rst_blank", 32'(blank), 0);
            chk_val("post_rst_mode", 32'(modeActive), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
